seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 60 ++++++
 rtl/bin2bcd_seq.sv | 99 +++++++++
 rtl/seg_scan_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the multiplexed 7-segment scanner.
//   - GLYPH_*    : 7-bit segment patterns {CG,CF,CE,CD,CC,CB,CA}, active-high
//   - DP_BIT     : position of the decimal point inside an 8-bit seg byte
//   - BCD_DIGITS : digits produced by the binary-to-BCD converter
//   - conv_state_e : converter FSM encoding, exported for debug
//   - hex_glyph()  : nibble -> 7-segment pattern
package seg_pkg;

    localparam int BCD_DIGITS = 10;
    localparam int DP_BIT     = 7;

    localparam logic [6:0] GLYPH_0     = 7'h3F;
    localparam logic [6:0] GLYPH_1     = 7'h06;
    localparam logic [6:0] GLYPH_2     = 7'h5B;
    localparam logic [6:0] GLYPH_3     = 7'h4F;
    localparam logic [6:0] GLYPH_4     = 7'h66;
    localparam logic [6:0] GLYPH_5     = 7'h6D;
    localparam logic [6:0] GLYPH_6     = 7'h7D;
    localparam logic [6:0] GLYPH_7     = 7'h07;
    localparam logic [6:0] GLYPH_8     = 7'h7F;
    localparam logic [6:0] GLYPH_9     = 7'h6F;
    localparam logic [6:0] GLYPH_A     = 7'h77;
    localparam logic [6:0] GLYPH_B     = 7'h7C;
    localparam logic [6:0] GLYPH_C     = 7'h39;
    localparam logic [6:0] GLYPH_D     = 7'h5E;
    localparam logic [6:0] GLYPH_E     = 7'h79;
    localparam logic [6:0] GLYPH_F     = 7'h71;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_DASH  = 7'h40;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_e;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 32-bit binary to 10-digit BCD converter
// (shift-add-3, one bit per clock).
//   clk, rst_n : clock, asynchronous active-low reset (aborts a conversion)
//   start      : accepted only in CONV_IDLE; samples bin
//   bin        : 32-bit binary input
//   busy       : high from the cycle after start until done is dropped
//   done       : one-cycle pulse, bcd is valid while done is high
//   bcd        : 10 BCD digits, digit 0 in bcd[3:0]
//   dbg_state  : current FSM state
//
// Timing: start at cycle T -> 32 shift steps on the edges ending
// T+1..T+32 -> done high during T+33 -> idle again at T+34.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               bin,
    output logic                      busy,
    output logic                      done,
    output logic [4*BCD_DIGITS-1:0]   bcd,
    output conv_state_e               dbg_state
);

    conv_state_e               state;
    conv_state_e               state_nxt;
    logic [31:0]               bin_sr;
    logic [4*BCD_DIGITS-1:0]   bcd_sr;
    logic [4*BCD_DIGITS-1:0]   bcd_adj;
    logic [4*BCD_DIGITS-1:0]   bcd_shift;
    logic [4:0]                step;
    // The top BCD bit cannot be set for any 32-bit input, so whatever is
    // shifted out of it is dropped.
    logic                      msb_unused;

    function automatic logic [4*BCD_DIGITS-1:0] add3(input logic [4*BCD_DIGITS-1:0] v);
        logic [4*BCD_DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign bcd_adj = add3(bcd_sr);
    assign {msb_unused, bcd_shift} = {bcd_adj, bin_sr[31]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= CONV_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            CONV_IDLE:  if (start) state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (step == 5'd31) state_nxt = CONV_DONE;
            CONV_DONE:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = (state != CONV_IDLE);
        done      = (state == CONV_DONE);
        bcd       = bcd_sr;
        dbg_state = state;
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            step   <= '0;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        bin_sr <= bin;
                        bcd_sr <= '0;
                        step   <= '0;
                    end
                end
                CONV_SHIFT: begin
                    bcd_sr <= bcd_shift;
                    bin_sr <= {bin_sr[30:0], 1'b0};
                    step   <= step + 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment display controller.
// Accepts a 32-bit value (hex or decimal), keeps a set of display
// registers, and time-multiplexes them onto NUM_BANKS banks of
// DIGITS_PER_BANK common-anode digits.
//   clk, rst_n  : clock, asynchronous active-low reset
//   upd_valid   : load request; num/mode_dec/lz_blank/dp_mask sampled on accept
//   upd_ready   : high when an update can be accepted (low during decimal conversion)
//   num         : binary value to show
//   mode_dec    : 1 = decimal (through bin2bcd_seq), 0 = hex (immediate)
//   lz_blank    : 1 = blank leading zeros (digit 0 always shown)
//   dp_mask     : decimal point per digit
//   seg         : per bank {DP,CG..CA}, registered, active-high
//   an          : anode enables, bit b*DIGITS_PER_BANK+k, registered, active-high
//   overflow    : value needs more than N digits; all digits show a dash
//
// Handshake: an update is taken in any cycle with upd_valid && upd_ready;
// upd_valid while upd_ready is low is dropped, never queued.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_BANKS       = 2,
    parameter int DIGITS_PER_BANK = 4,
    parameter int CLK_DIV         = 50000,
    parameter int GHOST_BLANK     = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   upd_valid,
    output logic                                   upd_ready,
    input  logic [31:0]                            num,
    input  logic                                   mode_dec,
    input  logic                                   lz_blank,
    input  logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   dp_mask,
    output logic [8*NUM_BANKS-1:0]                 seg,
    output logic [NUM_BANKS*DIGITS_PER_BANK-1:0]   an,
    output logic                                   overflow
);

    localparam int N  = NUM_BANKS * DIGITS_PER_BANK;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int KW = (DIGITS_PER_BANK > 1) ? $clog2(DIGITS_PER_BANK) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] GHOST_END  = PW'(GHOST_BLANK);
    localparam logic [KW-1:0] K_LAST     = KW'(DIGITS_PER_BANK - 1);

    // ------------------------------------------------------------------
    // Update acceptance and converter
    // ------------------------------------------------------------------
    logic                      accept;
    logic                      conv_start;
    logic                      hex_load;
    logic                      conv_busy;
    logic                      conv_done;
    logic [4*BCD_DIGITS-1:0]   conv_bcd;
    conv_state_e               conv_state;

    // Formatting flags for a decimal update, held until the conversion ends.
    logic                      pend_lz;
    logic [N-1:0]              pend_dp;

    // Ready is simply "converter idle": it drops the cycle after a decimal
    // accept and returns the cycle after done.
    assign upd_ready  = ~conv_busy;
    assign accept     = upd_valid & upd_ready;
    assign conv_start = accept & mode_dec;
    assign hex_load   = accept & ~mode_dec;

    bin2bcd_seq u_bin2bcd (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (conv_start),
        .bin       (num),
        .busy      (conv_busy),
        .done      (conv_done),
        .bcd       (conv_bcd),
        .dbg_state (conv_state)
    );

    busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
        conv_busy == (conv_state != CONV_IDLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_lz <= 1'b0;
            pend_dp <= '0;
        end else if (conv_start) begin
            pend_lz <= lz_blank;
            pend_dp <= dp_mask;
        end
    end

    // ------------------------------------------------------------------
    // New display contents (hex value or finished BCD result)
    // ------------------------------------------------------------------
    logic                      load;
    logic [4*BCD_DIGITS-1:0]   src_dig;
    logic                      src_lz;
    logic [N-1:0]              src_dp;
    logic                      src_ovf;
    logic [N-1:0]              src_blank;
    logic                      seen_nz;

    assign load = hex_load | conv_done;

    always_comb begin
        src_dig = {8'h00, num};
        src_lz  = lz_blank;
        src_dp  = dp_mask;
        if (conv_done) begin
            src_dig = conv_bcd;
            src_lz  = pend_lz;
            src_dp  = pend_dp;
        end

        // Any nonzero digit beyond the displayable range means overflow.
        // Hex nibbles 8 and 9 are always zero, so this also covers num>>(4N).
        src_ovf = 1'b0;
        for (int d = N; d < BCD_DIGITS; d++) begin
            if (src_dig[4*d +: 4] != 4'h0) src_ovf = 1'b1;
        end

        // Walk down from the top digit; blank until the first nonzero one.
        src_blank = '0;
        seen_nz   = 1'b0;
        for (int d = N - 1; d >= 1; d--) begin
            if (src_dig[4*d +: 4] != 4'h0) seen_nz = 1'b1;
            src_blank[d] = src_lz & ~seen_nz;
        end
    end

    // Display registers: written as one set in a single cycle.
    logic [4*N-1:0] disp_dig;
    logic [N-1:0]   disp_blank;
    logic [N-1:0]   disp_dp;
    logic           disp_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_dig   <= '0;
            disp_blank <= '0;
            disp_dp    <= '0;
            disp_ovf   <= 1'b0;
        end else if (load) begin
            disp_dig   <= src_dig[4*N-1:0];
            disp_blank <= src_blank;
            disp_dp    <= src_dp;
            disp_ovf   <= src_ovf;
        end
    end

    assign overflow = disp_ovf;

    // Per-digit segment byte. DP follows dp_mask even on blanked or dashed digits.
    logic [7:0] digit_seg [N];

    always_comb begin
        for (int d = 0; d < N; d++) begin
            logic [6:0] g;
            if (disp_ovf)           g = GLYPH_DASH;
            else if (disp_blank[d]) g = GLYPH_BLANK;
            else                    g = hex_glyph(disp_dig[4*d +: 4]);
            digit_seg[d] = {1'b0, g} | (8'(disp_dp[d]) << DP_BIT);
        end
    end

    // ------------------------------------------------------------------
    // Scanning
    // ------------------------------------------------------------------
    logic [PW-1:0]        presc;
    logic [PW-1:0]        presc_nxt;
    logic [KW-1:0]        k;
    logic [KW-1:0]        k_nxt;
    logic [8*NUM_BANKS-1:0] seg_nxt;
    logic [N-1:0]         an_nxt;

    // seg/an are registered from the post-edge prescaler and slot values,
    // so the outputs line up with presc/k in the same cycle.
    always_comb begin
        presc_nxt = presc + PW'(1);
        k_nxt     = k;
        if (presc == PRESC_LAST) begin
            presc_nxt = '0;
            k_nxt     = (k == K_LAST) ? '0 : k + KW'(1);
        end

        seg_nxt = '0;
        an_nxt  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            seg_nxt[8*b +: 8] = digit_seg[b*DIGITS_PER_BANK + int'(k_nxt)];
            if (presc_nxt >= GHOST_END) an_nxt[b*DIGITS_PER_BANK + int'(k_nxt)] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            k     <= '0;
            seg   <= '0;
            an    <= '0;
        end else begin
            presc <= presc_nxt;
            k     <= k_nxt;
            seg   <= seg_nxt;
            an    <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a short scan period
// (2 banks x 4 digits, CLK_DIV=4, GHOST_BLANK=1).
module tb_seg_scan_ctrl;

    localparam int NB      = 2;
    localparam int DPB     = 4;
    localparam int N       = NB * DPB;
    localparam int CLK_DIV = 4;
    localparam int GHOST   = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic            upd_valid = 1'b0;
    logic            upd_ready;
    logic [31:0]     num       = '0;
    logic            mode_dec  = 1'b0;
    logic            lz_blank  = 1'b0;
    logic [N-1:0]    dp_mask   = '0;
    logic [8*NB-1:0] seg;
    logic [N-1:0]    an;
    logic            overflow;

    seg_scan_ctrl #(
        .NUM_BANKS       (NB),
        .DIGITS_PER_BANK (DPB),
        .CLK_DIV         (CLK_DIV),
        .GHOST_BLANK     (GHOST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .num       (num),
        .mode_dec  (mode_dec),
        .lz_blank  (lz_blank),
        .dp_mask   (dp_mask),
        .seg       (seg),
        .an        (an),
        .overflow  (overflow)
    );

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Standard 7-segment patterns, bit0=CA .. bit6=CG.
    function automatic logic [7:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: return 8'h3F;  4'h1: return 8'h06;
            4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;
            4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;
            4'hA: return 8'h77;  4'hB: return 8'h7C;
            4'hC: return 8'h39;  4'hD: return 8'h5E;
            4'hE: return 8'h79;  default: return 8'h71;
        endcase
    endfunction

    // digits: expected digit values (nibble d = digit d), blank/dp per digit.
    task automatic push_expected(input logic [31:0] digits, input logic [N-1:0] blank,
                                 input logic [N-1:0] dp, input bit dash);
        for (int d = 0; d < N; d++) begin
            logic [7:0] g;
            if (dash)          g = 8'h40;
            else if (blank[d]) g = 8'h00;
            else               g = glyph(digits[4*d +: 4]);
            if (dp[d]) g = g | 8'h80;
            exp_q.push_back(g);
        end
    endtask

    // Watch two full scan rotations; compare each digit the first time its
    // anode is seen lit.
    task automatic scan_display(input string tag);
        logic [7:0]     exp_arr [N];
        bit             seen    [N];
        int             n_seen;
        int             kk;
        int             idx;
        logic [DPB-1:0] bank_an;
        check({tag, "_qsize"}, exp_q.size(), N);
        for (int d = 0; d < N; d++) begin
            exp_arr[d] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            seen[d]    = 1'b0;
        end
        n_seen = 0;
        repeat (2) @(posedge clk);
        for (int c = 0; c < 2 * CLK_DIV * DPB; c++) begin
            @(negedge clk);
            for (int b = 0; b < NB; b++) begin
                bank_an = an[b*DPB +: DPB];
                if (bank_an != '0) begin
                    kk = 0;
                    for (int i = DPB - 1; i >= 0; i--) if (bank_an[i]) kk = i;
                    idx = b * DPB + kk;
                    if (!seen[idx]) begin
                        seen[idx] = 1'b1;
                        n_seen++;
                        check($sformatf("%s_onehot_b%0d", tag, b), 32'(bank_an), 32'(1) << kk);
                        check($sformatf("%s_d%0d", tag, idx), 32'(seg[8*b +: 8]), 32'(exp_arr[idx]));
                    end
                end
            end
        end
        check({tag, "_seen"}, n_seen, N);
    endtask

    // ---------------- drivers ----------------
    // Returns just after the accept edge, i.e. at the start of cycle T+1.
    task automatic send(input logic [31:0] v, input bit dec, input bit lz, input logic [N-1:0] dp);
        @(negedge clk);
        upd_valid = 1'b1;
        num       = v;
        mode_dec  = dec;
        lz_blank  = lz;
        dp_mask   = dp;
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    // Follows a decimal accept from T+1 through T+34. Optionally offers a
    // hex update during T+5, which must be dropped.
    task automatic dec_wait(input string tag, input logic ovf_before, input logic ovf_after,
                            input bit inject);
        for (int i = 1; i <= 33; i++) begin
            if (inject && i == 5) begin
                upd_valid = 1'b1;
                num       = 32'h0000_0099;
                mode_dec  = 1'b0;
            end else if (inject && i == 6) begin
                upd_valid = 1'b0;
                mode_dec  = 1'b1;
            end
            @(negedge clk);
            check($sformatf("%s_rdy_low_T%0d", tag, i), 32'(upd_ready), 32'd0);
            if (i == 33) check({tag, "_ovf_T33"}, 32'(overflow), 32'(ovf_before));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({tag, "_rdy_T34"}, 32'(upd_ready), 32'd1);
        check({tag, "_ovf_T34"}, 32'(overflow), 32'(ovf_after));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state and first slots after release
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'h0);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_rdy", 32'(upd_ready), 32'h1);
        rst_n = 1'b1;
        #1 check("ghost_first", 32'(an), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("slot0_an_%0d", i), 32'(an), 32'h11);
            check($sformatf("slot0_seg_%0d", i), 32'(seg), 32'h3F3F);
        end
        @(negedge clk);
        check("ghost_slot1", 32'(an), 32'h0);
        @(negedge clk);
        check("slot1_an", 32'(an), 32'h22);
        check("slot1_seg", 32'(seg), 32'h3F3F);

        // Hex update: visible on the next cycle, ready stays high
        send(32'h1234_ABCD, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check("hex_ovf_T1", 32'(overflow), 32'h0);
        check("hex_rdy_T1", 32'(upd_ready), 32'h1);
        push_expected(32'h1234_ABCD, 8'h00, 8'h00, 1'b0);
        scan_display("hex");

        // Decimal 12345678 with a dropped update at T+5
        send(32'd12345678, 1'b1, 1'b1, 8'h00);
        dec_wait("dec8", 1'b0, 1'b0, 1'b1);
        push_expected(32'h1234_5678, 8'h00, 8'h00, 1'b0);
        scan_display("dec8");

        // Decimal overflow: 9 digits on an 8-digit display
        send(32'd100000000, 1'b1, 1'b0, 8'h00);
        dec_wait("decovf", 1'b0, 1'b1, 1'b0);
        push_expected(32'h0, 8'h00, 8'h00, 1'b1);
        scan_display("decovf");

        // Reset in the middle of a conversion
        send(32'd87654321, 1'b1, 1'b0, 8'hFF);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_an", 32'(an), 32'h0);
        check("midrst_seg", 32'(seg), 32'h0);
        check("midrst_ovf", 32'(overflow), 32'h0);
        check("midrst_rdy", 32'(upd_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("midrst_rdy_rel", 32'(upd_ready), 32'h1);
        push_expected(32'h0, 8'h00, 8'h00, 1'b0);
        scan_display("midrst_a");
        push_expected(32'h0, 8'h00, 8'h00, 1'b0);
        scan_display("midrst_b");

        // Decimal 42 with leading-zero blanking and DP on digit 0
        send(32'd42, 1'b1, 1'b1, 8'h01);
        dec_wait("dec42", 1'b0, 1'b0, 1'b0);
        push_expected(32'h0000_0042, 8'hFC, 8'h01, 1'b0);
        scan_display("dec42");

        // Hex with an interior zero run and leading-zero blanking
        send(32'h0000_0F00, 1'b0, 1'b1, 8'h00);
        @(negedge clk);
        check("hexlz_ovf_T1", 32'(overflow), 32'h0);
        check("hexlz_rdy_T1", 32'(upd_ready), 32'h1);
        push_expected(32'h0000_0F00, 8'hF8, 8'h00, 1'b0);
        scan_display("hexlz");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Time limit
    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "time limit reached");
    end

endmodule
